// File: rtl/cpu_core_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator CPU: datapath widths, opcode
// encodings, the fixed program ROM image and the RAM power-on/reset image.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_JC  = 3'b111;

    // Fixed program: load, add, store, subtract the stored sum, loop on zero.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            5'd0:    word = 8'h10;  // LDA 0x10
            5'd1:    word = 8'h51;  // ADD 0x11
            5'd2:    word = 8'h32;  // STA 0x12
            5'd3:    word = 8'h72;  // SUB 0x12
            5'd4:    word = 8'hC0;  // JZ  0x00
            default: word = 8'h00;  // LDA 0x00
        endcase
        return word;
    endfunction

    // Image loaded into data RAM whenever reset is asserted.
    function automatic logic [DATA_W-1:0] ram_init_word(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            5'h10:   word = 8'h05;
            5'h11:   word = 8'h03;
            default: word = 8'h00;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational ALU for the accumulator CPU.
// Ports:
//   a      in  8  accumulator operand
//   b      in  8  memory operand
//   op     in  3  instruction opcode
//   result out 8  LDA: b, ADD/SUB/AND: operation result, others: a
//   carry  out 1  ADD: carry-out, SUB: borrow (a < b), otherwise 0
//   zero   out 1  result == 0
// -----------------------------------------------------------------------------
module alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Nine-bit arithmetic: bit 8 of the difference is set exactly when a < b.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Result and carry selection by opcode; STA and jumps pass the accumulator.
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDA: result = b;
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            OP_AND: result = a & b;
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core
// Single-cycle 8-bit accumulator CPU with a fixed 32x8 program ROM, a 32x8
// data RAM, accumulator, carry/zero flags and a 5-bit PC. One instruction
// executes per clock; all architectural state commits on the rising edge.
// Ports:
//   clk_i     in  1  system clock
//   reset_i   in  1  asynchronous active-high reset (also reloads RAM image)
//   reg_acc_o out 8  accumulator
//   reg_sw_o  out 2  status word {C, Z}
//   curr_pc   out 5  program counter
//   curr_ins  out 8  ROM[curr_pc]
//   addr_o    out 5  operand address curr_ins[4:0]
//   bus_ram_o out 8  RAM[addr_o], asynchronous read
//   wr_o      out 1  accumulator write enable of the current instruction
//   wm_o      out 1  RAM write enable of the current instruction
//   bus_alu_o out 8  ALU result of the current instruction
// -----------------------------------------------------------------------------
module cpu_core
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [DATA_W-1:0] reg_acc_o,
    output logic [1:0]        reg_sw_o,
    output logic [ADDR_W-1:0] curr_pc,
    output logic [DATA_W-1:0] curr_ins,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] bus_ram_o,
    output logic              wr_o,
    output logic              wm_o,
    output logic [DATA_W-1:0] bus_alu_o
);

    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] acc_r;
    logic              c_r;
    logic              z_r;
    logic [DATA_W-1:0] ram_r [0:(1<<ADDR_W)-1];

    logic [DATA_W-1:0] ins_s;
    logic [2:0]        op_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] ram_rd_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_c_s;
    logic              alu_z_s;
    logic              wr_s;
    logic              wm_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic              c_next_s;
    logic              z_next_s;

    assign ins_s    = rom_word(pc_r);
    assign op_s     = ins_s[7:5];
    assign addr_s   = ins_s[4:0];
    assign ram_rd_s = ram_r[addr_s];

    alu u_alu (
        .a      (acc_r),
        .b      (ram_rd_s),
        .op     (op_s),
        .result (alu_res_s),
        .carry  (alu_c_s),
        .zero   (alu_z_s)
    );

    // Control decode: write enables, next PC and next flag values.
    always_comb begin
        wr_s      = 1'b0;
        wm_s      = 1'b0;
        pc_next_s = pc_r + 5'd1;
        c_next_s  = c_r;
        z_next_s  = z_r;
        case (op_s)
            OP_LDA: begin
                wr_s     = 1'b1;
                z_next_s = alu_z_s;   // carry is preserved across loads
            end
            OP_STA: wm_s = 1'b1;
            OP_ADD, OP_SUB, OP_AND: begin
                wr_s     = 1'b1;
                c_next_s = alu_c_s;
                z_next_s = alu_z_s;
            end
            OP_JMP: pc_next_s = addr_s;
            OP_JZ: begin
                if (z_r) begin
                    pc_next_s = addr_s;
                end else begin
                    pc_next_s = pc_r + 5'd1;
                end
            end
            OP_JC: begin
                if (c_r) begin
                    pc_next_s = addr_s;
                end else begin
                    pc_next_s = pc_r + 5'd1;
                end
            end
            default: begin
                wr_s = 1'b0;
                wm_s = 1'b0;
            end
        endcase
    end

    // Architectural registers: PC, accumulator and flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_r  <= 5'd0;
            acc_r <= 8'h00;
            c_r   <= 1'b0;
            z_r   <= 1'b0;
        end else begin
            pc_r <= pc_next_s;
            if (wr_s) begin
                acc_r <= alu_res_s;
            end
            c_r <= c_next_s;
            z_r <= z_next_s;
        end
    end

    // Data RAM: reset restores the initial image, STA writes on the edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                ram_r[i] <= ram_init_word(ADDR_W'(i));
            end
        end else if (wm_s) begin
            ram_r[addr_s] <= acc_r;
        end
    end

    assign reg_acc_o = acc_r;
    assign reg_sw_o  = {c_r, z_r};
    assign curr_pc   = pc_r;
    assign curr_ins  = ins_s;
    assign addr_o    = addr_s;
    assign bus_ram_o = ram_rd_s;
    assign wr_o      = wr_s;
    assign wm_o      = wm_s;
    assign bus_alu_o = alu_res_s;

endmodule

// File: tb/tb_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_cpu_core
// Self-checking bench for cpu_core with an instruction-level reference model
// and a standalone alu instance for operand-level checks.
// -----------------------------------------------------------------------------
module tb_cpu_core;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] reg_acc_o;
    logic [1:0] reg_sw_o;
    logic [4:0] curr_pc;
    logic [7:0] curr_ins;
    logic [4:0] addr_o;
    logic [7:0] bus_ram_o;
    logic       wr_o;
    logic       wm_o;
    logic [7:0] bus_alu_o;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] m_rom [32];
    logic [7:0] m_mem [32];
    logic [7:0] m_acc;
    logic       m_c;
    logic       m_z;
    logic [4:0] m_pc;

    cpu_core dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .reg_acc_o (reg_acc_o),
        .reg_sw_o  (reg_sw_o),
        .curr_pc   (curr_pc),
        .curr_ins  (curr_ins),
        .addr_o    (addr_o),
        .bus_ram_o (bus_ram_o),
        .wr_o      (wr_o),
        .wm_o      (wm_o),
        .bus_alu_o (bus_alu_o)
    );

    alu u_alu_ut (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always #5 clk_i = ~clk_i;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_mem[16] = 8'h05;
        m_mem[17] = 8'h03;
        m_acc = 8'h00;
        m_c   = 1'b0;
        m_z   = 1'b0;
        m_pc  = 5'd0;
    endtask

    // One instruction of the architecture, written from the instruction table.
    task automatic model_step();
        logic [7:0] ins;
        int         op;
        int         a;
        int         m;
        int         s;
        ins = m_rom[m_pc];
        op  = int'(ins) / 32;
        a   = int'(ins) % 32;
        m   = int'(m_mem[a]);
        m_pc = m_pc + 5'd1;
        case (op)
            0: begin m_acc = 8'(m); m_z = (m == 0); end
            1: m_mem[a] = m_acc;
            2: begin
                s = int'(m_acc) + m;
                m_c = (s > 255);
                m_acc = 8'(s % 256);
                m_z = (m_acc == 8'h00);
            end
            3: begin
                s = int'(m_acc) - m;
                m_c = (s < 0);
                m_acc = 8'((s + 256) % 256);
                m_z = (m_acc == 8'h00);
            end
            4: begin m_acc = m_acc & 8'(m); m_c = 1'b0; m_z = (m_acc == 8'h00); end
            5: m_pc = 5'(a);
            6: if (m_z) m_pc = 5'(a);
            7: if (m_c) m_pc = 5'(a);
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string ph);
        logic [7:0] ins;
        int         op;
        int         a;
        logic [7:0] m;
        logic [7:0] e_alu;
        ins = m_rom[m_pc];
        op  = int'(ins) / 32;
        a   = int'(ins) % 32;
        m   = m_mem[a];
        case (op)
            0: e_alu = m;
            2: e_alu = 8'((int'(m_acc) + int'(m)) % 256);
            3: e_alu = 8'((int'(m_acc) - int'(m) + 256) % 256);
            4: e_alu = m_acc & m;
            default: e_alu = m_acc;
        endcase
        check8({ph, ":acc"}, reg_acc_o, m_acc);
        check8({ph, ":sw"},  {6'd0, reg_sw_o}, {6'd0, m_c, m_z});
        check8({ph, ":pc"},  {3'd0, curr_pc}, {3'd0, m_pc});
        check8({ph, ":ins"}, curr_ins, ins);
        check8({ph, ":addr"}, {3'd0, addr_o}, 8'(a));
        check8({ph, ":ram"}, bus_ram_o, m);
        check8({ph, ":wr"},  {7'd0, wr_o}, (op == 0 || op == 2 || op == 3 || op == 4) ? 8'd1 : 8'd0);
        check8({ph, ":wm"},  {7'd0, wm_o}, (op == 1) ? 8'd1 : 8'd0);
        check8({ph, ":alu"}, bus_alu_o, e_alu);
    endtask

    task automatic cycle(input string ph);
        @(posedge clk_i);
        if (!reset_i) model_step();
        @(negedge clk_i);
        check_outputs(ph);
    endtask

    task automatic alu_check(input string tag, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        logic [7:0] e_res;
        logic       e_c;
        int         s;
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        case (op)
            3'd2: begin s = int'(a) + int'(b); e_res = 8'(s % 256); e_c = (s > 255); end
            3'd3: begin s = int'(a) - int'(b); e_res = 8'((s + 256) % 256); e_c = (s < 0); end
            3'd4: begin e_res = a & b; e_c = 1'b0; end
            default: begin e_res = b; e_c = 1'b0; end
        endcase
        check8({tag, ":res"}, alu_result, e_res);
        check8({tag, ":z"}, {7'd0, alu_zero}, (e_res == 8'h00) ? 8'd1 : 8'd0);
        if (op != 3'd0) check8({tag, ":c"}, {7'd0, alu_carry}, {7'd0, e_c});
    endtask

    initial begin
        int          n;
        int          d;
        logic [2:0]  ops [4];
        for (int i = 0; i < 32; i++) m_rom[i] = 8'h00;
        m_rom[0] = 8'h10;
        m_rom[1] = 8'h51;
        m_rom[2] = 8'h32;
        m_rom[3] = 8'h72;
        m_rom[4] = 8'hC0;
        ops[0] = 3'd0; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd4;
        alu_a = 8'h00; alu_b = 8'h00; alu_op = 3'd0;

        // Reset state
        reset_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        check_outputs("reset");
        check8("rst_ins", curr_ins, 8'h10);
        check8("rst_ram", bus_ram_o, 8'h05);
        check8("rst_alu", bus_alu_o, 8'h05);
        check8("rst_wr", {7'd0, wr_o}, 8'd1);
        reset_i = 1'b0;
        #1;
        check_outputs("release");

        // Directed walk through the program loop
        cycle("lda");
        check8("s2_acc", reg_acc_o, 8'h05);
        check8("s2_pc", {3'd0, curr_pc}, 8'd1);
        check8("s2_ins", curr_ins, 8'h51);
        check8("s2_alu", bus_alu_o, 8'h08);
        cycle("add");
        check8("s3_acc", reg_acc_o, 8'h08);
        check8("s3_sw", {6'd0, reg_sw_o}, 8'd0);
        check8("s3_wm", {7'd0, wm_o}, 8'd1);
        check8("s3_wr", {7'd0, wr_o}, 8'd0);
        cycle("sta");
        check8("s3_pc", {3'd0, curr_pc}, 8'd3);
        check8("s3_ram12", dut.ram_r[5'd18], 8'h08);
        cycle("sub");
        check8("s4_acc", reg_acc_o, 8'h00);
        check8("s4_sw", {6'd0, reg_sw_o}, 8'd1);
        cycle("jz");
        check8("s4_pc", {3'd0, curr_pc}, 8'd0);
        for (int i = 0; i < 3; i++) cycle("loop");

        // Asynchronous reset at PC = 3, between edges
        check8("s5_pc_pre", {3'd0, curr_pc}, 8'd3);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check_outputs("areset");
        check8("s5_ram12", dut.ram_r[5'd18], 8'h00);
        @(negedge clk_i);
        check_outputs("areset_hold");
        reset_i = 1'b0;
        #1;

        // Random run lengths and randomly placed reset pulses
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 25);
            repeat (n) cycle("rand");
            d = $urandom_range(1, 3);
            #(d);
            reset_i = 1'b1;
            model_reset();
            #1;
            check_outputs("rand_rst");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk_i);
                check_outputs("rand_rst_hold");
                reset_i = 1'b0;
                #1;
            end else begin
                reset_i = 1'b0;
                @(negedge clk_i);
                model_step();
                check_outputs("rand_short_rst");
            end
        end

        // ALU unit checks: directed corners then random operands
        alu_check("alu_add_wrap", 3'd2, 8'hFF, 8'h01);
        check8("alu_add_wrap_exp", {alu_result[7:0]}, 8'h00);
        check8("alu_add_wrap_cz", {6'd0, alu_carry, alu_zero}, 8'd3);
        alu_check("alu_sub_borrow", 3'd3, 8'h03, 8'h05);
        check8("alu_sub_borrow_exp", alu_result, 8'hFE);
        check8("alu_sub_borrow_c", {7'd0, alu_carry}, 8'd1);
        alu_check("alu_and_zero", 3'd4, 8'hF0, 8'h0F);
        check8("alu_and_zero_cz", {6'd0, alu_carry, alu_zero}, 8'd1);
        for (int k = 0; k < 40; k++) begin
            alu_check("alu_rand", ops[$urandom_range(0, 3)], 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
